// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity encodings, FSM states,
// oversampling constants and the parity-check helper.
package uart_pkg;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  // Oversampling ratio and the mid-bit sampling phase of os_cnt.
  localparam int         OVS = 16;
  localparam logic [3:0] MID = 4'd7;

  // Width of the baud tick divider counter.
  localparam int TICK_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_t;

  // True when the selected parity mode carries a parity bit on the line.
  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

  // Parity mismatch between a data word and its received parity bit.
  function automatic logic parity_mismatch(input logic [7:0] data,
                                           input logic       pbit,
                                           input logic [1:0] ptype);
    logic red;
    red = ^data;
    case (ptype)
      PAR_ODD:  return red == pbit;
      PAR_EVEN: return red != pbit;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: one-clk pulse every (DIVn+1) clocks, divisor
// picked live by baud_sel.
module uart_rx_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV0 = 80,
  parameter int unsigned DIV1 = 40,
  parameter int unsigned DIV2 = 19,
  parameter int unsigned DIV3 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  output logic       tick
);

  logic [TICK_W-1:0] cnt;
  logic [TICK_W-1:0] div;

  // Divisor mux for the selected baud rate.
  always_comb begin
    div = TICK_W'(DIV0);
    case (baud_sel)
      2'b00:   div = TICK_W'(DIV0);
      2'b01:   div = TICK_W'(DIV1);
      2'b10:   div = TICK_W'(DIV2);
      default: div = TICK_W'(DIV3);
    endcase
  end

  // A lowered divisor that the counter has already passed still wraps at
  // once instead of running the counter all the way round.
  assign tick = (cnt >= div);

  // Free-running divider counter, wrapping on every tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, 7/8 data bits LSB first, optional odd/even
// parity, 1 or 2 stop bits, valid/ready output with parity, framing and
// overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DIV0 = 80,
  parameter int unsigned DIV1 = 40,
  parameter int unsigned DIV2 = 19,
  parameter int unsigned DIV3 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [1:0] baud_sel,
  input  logic       data_length,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  rx_state_t  state, state_n;

  logic       tick;
  logic       rx_p0, rx_p1, rx_p2;
  logic       line, fall, mid;

  logic [3:0] os_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       last_bit;

  logic       cfg_len8;
  logic [1:0] cfg_par;
  logic       cfg_stop2;

  logic       par_err_acc;
  logic       frame_err_acc;

  logic       latch_cfg, start_ok, false_start;
  logic       shift_en, par_en, stop_en, commit;
  logic       accept;

  uart_rx_tick #(
    .DIV0(DIV0),
    .DIV1(DIV1),
    .DIV2(DIV2),
    .DIV3(DIV3)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .baud_sel(baud_sel),
    .tick    (tick)
  );

  // Two-flop synchroniser for the asynchronous line plus one history flop
  // for falling-edge detection; all idle high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx_in;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // ---- stage boundary: synchronised line ----
  assign line     = rx_p1;
  assign fall     = rx_p2 & ~rx_p1;
  assign mid      = tick & (os_cnt == MID);
  assign last_bit = (bit_idx == (cfg_len8 ? 3'd7 : 3'd6));
  assign accept   = rx_valid & rx_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and one-clk action strobes for the datapath.
  always_comb begin
    state_n     = state;
    latch_cfg   = 1'b0;
    start_ok    = 1'b0;
    false_start = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          latch_cfg = 1'b1;
          state_n   = START;
        end
      end
      START: begin
        if (mid) begin
          if (!line) begin
            start_ok = 1'b1;
            state_n  = DATA;
          end else begin
            false_start = 1'b1;
            state_n     = IDLE;
          end
        end
      end
      DATA: begin
        if (mid) begin
          shift_en = 1'b1;
          if (last_bit) begin
            state_n = parity_enabled(cfg_par) ? PARITY : STOP1;
          end
        end
      end
      PARITY: begin
        if (mid) begin
          par_en  = 1'b1;
          state_n = STOP1;
        end
      end
      STOP1: begin
        if (mid) begin
          stop_en = 1'b1;
          if (cfg_stop2) begin
            state_n = STOP2;
          end else begin
            commit  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      STOP2: begin
        if (mid) begin
          stop_en = 1'b1;
          commit  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Oversample counter: restarts at the start-bit edge and then runs freely,
  // so the START mid-bit sample at os_cnt==7 is followed by DATA, PARITY and
  // STOP samples exactly 16 ticks apart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      os_cnt <= '0;
    end else if (latch_cfg) begin
      os_cnt <= '0;
    end else if (tick) begin
      os_cnt <= (os_cnt == 4'(OVS - 1)) ? 4'd0 : os_cnt + 4'd1;
    end
  end

  // Frame configuration captured at start detect and held for the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_len8  <= 1'b0;
      cfg_par   <= PAR_NONE;
      cfg_stop2 <= 1'b0;
    end else if (latch_cfg) begin
      cfg_len8  <= data_length;
      cfg_par   <= parity_type;
      cfg_stop2 <= stop_bits;
    end
  end

  // Bit index and per-frame error accumulators.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx       <= '0;
      par_err_acc   <= 1'b0;
      frame_err_acc <= 1'b0;
    end else begin
      if (start_ok) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (start_ok) begin
        par_err_acc <= 1'b0;
      end else if (par_en) begin
        par_err_acc <= parity_mismatch(shift, line, cfg_par);
      end
      if (start_ok) begin
        frame_err_acc <= 1'b0;
      end else if (stop_en && !line) begin
        frame_err_acc <= 1'b1;
      end
    end
  end

  // Data shift register; cleared per frame so bit 7 stays 0 for 7-bit words.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      shift <= '0;
    end else if (shift_en) begin
      shift[bit_idx] <= line;
    end
  end

  // ---- stage boundary: committed word and handshake ----
  // Busy flag spans start detect to commit or false start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_busy <= 1'b0;
    end else if (latch_cfg) begin
      rx_busy <= 1'b1;
    end else if (false_start || commit) begin
      rx_busy <= 1'b0;
    end
  end

  // Output word, flags and valid; a commit on the accept clk wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit) begin
      rx_data    <= shift;
      rx_valid   <= 1'b1;
      parity_err <= par_err_acc;
      frame_err  <= frame_err_acc | ~line;
      overrun    <= rx_valid & ~rx_ready;
    end else if (accept) begin
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames at the fastest baud setting, a
// frame-level reference model checked every cycle, plus literal expectations.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [1:0] baud_sel;
  logic       data_length;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  uart_rx dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .baud_sel   (baud_sel),
    .data_length(data_length),
    .parity_type(parity_type),
    .stop_bits  (stop_bits),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  exp_t       cur;
  logic       exp_valid = 1'b0;
  logic       exp_ov    = 1'b0;
  logic       acc_pend  = 1'b0;
  logic       prev_busy = 1'b0;
  int         n_commit  = 0;
  int         valid_cycles = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] cap_data  = 8'h00;
  logic       cap_pe    = 1'b0;
  logic       cap_fe    = 1'b0;
  logic       cap_ov    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: a word becomes pending when the frame ends (busy drops
  // with a frame outstanding), leaves when accepted, and is compared every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      exp_valid = 1'b0;
      exp_ov    = 1'b0;
      acc_pend  = 1'b0;
      prev_busy = 1'b0;
      chk("rst_outputs", {rx_data, rx_valid, parity_err, frame_err, overrun, rx_busy}, 32'h0);
    end else begin
      if (prev_busy && !rx_busy && q.size() > 0) begin
        cur       = q.pop_front();
        exp_ov    = exp_valid && !acc_pend;
        exp_valid = 1'b1;
        n_commit++;
        cap_data  = rx_data;
        cap_pe    = parity_err;
        cap_fe    = frame_err;
        cap_ov    = overrun;
      end else if (acc_pend) begin
        exp_valid = 1'b0;
      end
      chk("rx_valid", rx_valid, exp_valid);
      if (exp_valid) begin
        chk("rx_data", rx_data, cur.d);
        chk("flags", {parity_err, frame_err, overrun}, {cur.pe, cur.fe, exp_ov});
      end else begin
        chk("flags_idle", {parity_err, frame_err, overrun}, 3'b000);
      end
      if (rx_valid) valid_cycles++;
      if (rx_busy) busy_seen = 1'b1;
      acc_pend  = rx_valid && rx_ready;
      prev_busy = rx_busy;
    end
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame and queues what the receiver must report for it.
  task automatic send_frame(input logic [7:0] d, input logic len8, input logic [1:0] par,
                            input logic stp2, input logic pbit, input logic stop_val,
                            input logic twiddle);
    exp_t e;
    int   ones;
    int   nbits;
    e.d   = len8 ? d : {1'b0, d[6:0]};
    ones  = $countones(e.d) + int'(pbit);
    if (par == 2'b01)      e.pe = (ones % 2) == 0;
    else if (par == 2'b10) e.pe = (ones % 2) == 1;
    else                   e.pe = 1'b0;
    e.fe  = ~stop_val;
    nbits = len8 ? 8 : 7;
    data_length = len8;
    parity_type = par;
    stop_bits   = stp2;
    q.push_back(e);
    drive_bit(1'b0);
    if (twiddle) begin
      data_length = ~len8;
      parity_type = par ^ 2'b01;
      stop_bits   = ~stp2;
    end
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (par == 2'b01 || par == 2'b10) drive_bit(pbit);
    drive_bit(stop_val);
    if (stp2) drive_bit(stop_val);
    data_length = len8;
    parity_type = par;
    stop_bits   = stp2;
    chk("frame_committed", q.size(), 0);
  endtask

  initial begin
    int base;
    rst         = 1'b0;
    rx_in       = 1'b1;
    baud_sel    = 2'b11;
    data_length = 1'b1;
    parity_type = 2'b00;
    stop_bits   = 1'b0;
    rx_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", rx_valid, 1'b0);
    chk("reset_busy", rx_busy, 1'b0);
    rst = 1'b1;
    idle(20);

    // 1: 8N1 0xA5 with ready high; config twiddled mid-frame
    valid_cycles = 0;
    send_frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(10);
    chk("t1_data", cap_data, 8'hA5);
    chk("t1_flags", {cap_pe, cap_fe, cap_ov}, 3'b000);
    chk("t1_valid_one_clk", valid_cycles, 1);
    chk("t1_busy_low", rx_busy, 1'b0);

    // 2: 7O2 0x35, parity bit 1 then parity bit 0
    send_frame(8'h35, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(10);
    chk("t2_data", cap_data, 8'h35);
    chk("t2_pe_good", cap_pe, 1'b0);
    send_frame(8'h35, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("t2_pe_bad", cap_pe, 1'b1);

    // 3: 8E1 0x0F with stop bit low
    send_frame(8'h0F, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(BIT_CLK);
    chk("t3_data", cap_data, 8'h0F);
    chk("t3_fe", cap_fe, 1'b1);
    chk("t3_pe", cap_pe, 1'b0);

    // 4: 20-clk glitch on an idle line
    base      = n_commit;
    busy_seen = 1'b0;
    rx_in     = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    idle(100);
    chk("t4_busy_pulse", busy_seen, 1'b1);
    chk("t4_busy_low", rx_busy, 1'b0);
    chk("t4_no_commit", n_commit - base, 0);
    chk("t4_no_valid", rx_valid, 1'b0);

    // 5: back-to-back 0x11, 0x22 with ready low, then accept
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("t5_data", cap_data, 8'h22);
    chk("t5_overrun", cap_ov, 1'b1);
    chk("t5_valid_held", rx_valid, 1'b1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    idle(2);
    chk("t5_valid_cleared", rx_valid, 1'b0);
    chk("t5_overrun_cleared", overrun, 1'b0);

    // 6: reset in the middle of DATA, then a clean 0x5A
    data_length = 1'b1;
    parity_type = 2'b00;
    stop_bits   = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    chk("t6_busy_mid", rx_busy, 1'b1);
    rx_in = 1'b1;
    rst   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_rst_data", rx_data, 8'h00);
    chk("t6_rst_busy", rx_busy, 1'b0);
    chk("t6_rst_valid", rx_valid, 1'b0);
    rst = 1'b1;
    idle(BIT_CLK);
    rx_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("t6_data", cap_data, 8'h5A);
    chk("t6_flags", {cap_pe, cap_fe, cap_ov}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
